// File: rtl/mac_seq_ctrl_pkg.sv
// Shared state encoding, default widths and psum sign-extension helper for the MAC sequencer.
package mac_seq_ctrl_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam int unsigned def_bw    = 8;
   localparam int unsigned def_pr    = 8;
   localparam int unsigned def_len_w = 8;

   // Sign-extend the low 'width' bits of psum to 64 bits; callers keep the bits they need.
   function automatic logic [63:0] sext_psum(input logic [63:0] psum, input int unsigned width);
      logic [63:0] shifted;
      shifted = psum << (64 - width);
      return $signed(shifted) >>> (64 - width);
   endfunction

endpackage

// File: rtl/mac_seq_acc.sv
// Wide signed accumulator: clears on an accepted job start, adds the sign-extended psum on fire_q.
module mac_seq_acc #(
   parameter int unsigned bw_psum = 22,
   parameter int unsigned acc_bw  = 30
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              fire_q,
   input  logic [bw_psum-1:0] mac_out,
   output logic [acc_bw-1:0]  acc
);
   import mac_seq_ctrl_pkg::*;

   logic [63:0]       psum_ext;
   logic [acc_bw-1:0] acc_d;
   logic              unused_ext;

   always_comb begin
      psum_ext = sext_psum(64'(mac_out), bw_psum);
      acc_d    = acc;
      if (clear) begin
         acc_d = '0;
      end else if (fire_q) begin
         acc_d = acc + psum_ext[acc_bw-1:0];
      end
   end

   // Upper extension bits are only sign copies.
   assign unused_ext = ^psum_ext[63:acc_bw];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc <= '0;
      end else begin
         acc <= acc_d;
      end
   end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product job sequencer for the 8-lane MAC: streams beats, accumulates psums, returns result.
// Define MAC_SEQ_CTRL_RELU_EN to clamp negative results to zero on out_data only.
module mac_seq_ctrl
   import mac_seq_ctrl_pkg::*;
#(
   parameter int unsigned bw      = def_bw,
   parameter int unsigned pr      = def_pr,
   parameter int unsigned len_w   = def_len_w,
   parameter int unsigned bw_psum = 2 * bw + 6,
   parameter int unsigned acc_bw  = bw_psum + len_w
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [len_w-1:0]    cfg_len,
   output logic                busy,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [pr*bw-1:0]    in_a,
   input  logic [pr*bw-1:0]    in_b,
   output logic [pr*bw-1:0]    mac_a,
   output logic [pr*bw-1:0]    mac_b,
   input  logic [bw_psum-1:0]  mac_out,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [acc_bw-1:0]   out_data
);

   logic [1:0]        state_q, state_d;
   logic [len_w-1:0]  count_q, count_d;
   logic              fire, fire_q;
   logic              clear;
   logic [acc_bw-1:0] acc;

   assign busy      = (state_q != IDLE);
   assign in_ready  = (state_q == RUN);
   assign out_valid = (state_q == DONE);
   assign fire      = in_valid & in_ready;
   assign clear     = (state_q == IDLE) & start;

   // Bubbles present zero operands so the MAC produces a zero product.
   assign mac_a = fire ? in_a : '0;
   assign mac_b = fire ? in_b : '0;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               count_d = cfg_len;
               state_d = (cfg_len != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            if (fire) begin
               count_d = count_q - len_w'(1);
               if (count_q == len_w'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: state_d = DONE;
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         count_q <= '0;
         fire_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         fire_q  <= fire;
      end
   end

   mac_seq_acc #(
      .bw_psum (bw_psum),
      .acc_bw  (acc_bw)
   ) u_acc (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear),
      .fire_q  (fire_q),
      .mac_out (mac_out),
      .acc     (acc)
   );

`ifdef MAC_SEQ_CTRL_RELU_EN
   assign out_data = acc[acc_bw-1] ? '0 : acc;
`else
   assign out_data = acc;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a registered 1-cycle-latency behavioural MAC.
module tb_mac_seq_ctrl;

   localparam int unsigned bw      = 8;
   localparam int unsigned pr      = 8;
   localparam int unsigned len_w   = 8;
   localparam int unsigned bw_psum = 2 * bw + 6;
   localparam int unsigned acc_bw  = bw_psum + len_w;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic                start = 1'b0;
   logic [len_w-1:0]    cfg_len = '0;
   logic                busy;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [pr*bw-1:0]    in_a = '0;
   logic [pr*bw-1:0]    in_b = '0;
   logic [pr*bw-1:0]    mac_a;
   logic [pr*bw-1:0]    mac_b;
   logic [bw_psum-1:0]  mac_out;
   logic                out_valid;
   logic                out_ready = 1'b0;
   logic [acc_bw-1:0]   out_data;

   int checks = 0;
   int passed = 0;

   mac_seq_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .cfg_len   (cfg_len),
      .busy      (busy),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .mac_a     (mac_a),
      .mac_b     (mac_b),
      .mac_out   (mac_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   function automatic logic [bw_psum-1:0] dot(input logic [pr*bw-1:0] a, input logic [pr*bw-1:0] b);
      logic signed [bw_psum-1:0] s;
      logic signed [bw_psum-1:0] pa;
      logic signed [bw_psum-1:0] pb;
      s = '0;
      for (int i = 0; i < int'(pr); i++) begin
         pa = $signed(a[i*bw +: bw]);
         pb = $signed(b[i*bw +: bw]);
         s  = s + pa * pb;
      end
      return s;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) mac_out <= '0;
      else        mac_out <= dot(mac_a, mac_b);
   end

   function automatic logic [pr*bw-1:0] fill(input logic [bw-1:0] v);
      return {pr{v}};
   endfunction

   task automatic start_job(input logic [len_w-1:0] len);
      @(negedge clk);
      start   = 1'b1;
      cfg_len = len;
      @(negedge clk);
      start = 1'b0;
      #1;
   endtask

   task automatic stream(input bit toggle, input int max_cyc, output int nfire);
      nfire = 0;
      for (int k = 0; k < max_cyc; k++) begin
         if (!in_ready) break;
         in_valid = toggle ? (k % 2 == 0) : 1'b1;
         #1;
         if (in_valid) nfire++;
         if (toggle && !in_valid) begin
            checks++;
            if (mac_a !== '0 || mac_b !== '0)
               $display("FAIL bubble_zero: mac_a=%h mac_b=%h want 0", mac_a, mac_b);
            else passed++;
         end
         @(negedge clk);
         #1;
      end
      in_valid = 1'b0;
      #1;
   endtask

   task automatic wait_out(input int max_cyc);
      for (int k = 0; k < max_cyc; k++) begin
         if (out_valid) break;
         @(negedge clk);
         #1;
      end
      checks++;
      if (out_valid !== 1'b1) $display("FAIL out_valid_timeout: out_valid=%b want 1", out_valid);
      else passed++;
   endtask

   task automatic accept;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL handshake_idle: out_valid=%b busy=%b want 0 0", out_valid, busy);
      else passed++;
   endtask

   task automatic test_reset;
      in_a = fill(8'h11);
      in_b = fill(8'h22);
      in_valid = 1'b1;
      #12;
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0)
         $display("FAIL reset_ctrl: busy=%b in_ready=%b out_valid=%b want 000",
                  busy, in_ready, out_valid);
      else passed++;
      checks++;
      if (out_data !== '0 || mac_a !== '0 || mac_b !== '0)
         $display("FAIL reset_data: out_data=%h mac_a=%h mac_b=%h want 0", out_data, mac_a, mac_b);
      else passed++;
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
   endtask

   task automatic test_single_beat;
      start_job(8'd1);
      in_a = fill(8'd1);
      in_b = fill(8'd2);
      in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || mac_a !== in_a || mac_b !== in_b)
         $display("FAIL single_fire: in_ready=%b mac_a=%h want 1 %h", in_ready, mac_a, in_a);
      else passed++;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1)
         $display("FAIL single_drain: out_valid=%b in_ready=%b busy=%b want 0 0 1",
                  out_valid, in_ready, busy);
      else passed++;
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== acc_bw'(16))
         $display("FAIL single_result: out_valid=%b out_data=%0d want 1 16",
                  out_valid, $signed(out_data));
      else passed++;
      accept();
   endtask

   task automatic test_bubbles;
      int nfire;
      logic [acc_bw-1:0] exp;
`ifdef MAC_SEQ_CTRL_RELU_EN
      exp = '0;
`else
      exp = acc_bw'(-480);
`endif
      start_job(8'd4);
      in_a = fill(8'hFD);
      in_b = fill(8'd5);
      stream(1'b1, 40, nfire);
      checks++;
      if (nfire !== 4) $display("FAIL bubbles_fires: got %0d want 4", nfire);
      else passed++;
      wait_out(10);
      checks++;
      if (out_data !== exp)
         $display("FAIL bubbles_result: out_data=%0d want %0d", $signed(out_data), $signed(exp));
      else passed++;
      accept();
   endtask

   task automatic test_zero_len;
      start_job(8'd0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== '0 || in_ready !== 1'b0)
         $display("FAIL zero_len: out_valid=%b out_data=%0d in_ready=%b want 1 0 0",
                  out_valid, $signed(out_data), in_ready);
      else passed++;
      accept();
   endtask

   task automatic test_max_len;
      int nfire;
      start_job(8'd255);
      in_a = fill(8'h80);
      in_b = fill(8'h80);
      stream(1'b0, 300, nfire);
      checks++;
      if (nfire !== 255) $display("FAIL max_fires: got %0d want 255", nfire);
      else passed++;
      wait_out(10);
      checks++;
      if (out_data !== acc_bw'(33423360))
         $display("FAIL max_result: out_data=%0d want 33423360", $signed(out_data));
      else passed++;
      accept();
   endtask

   task automatic test_backpressure;
      int nfire;
      start_job(8'd1);
      in_a = fill(8'd2);
      in_b = fill(8'd3);
      stream(1'b0, 10, nfire);
      wait_out(10);
      for (int k = 0; k < 5; k++) begin
         start   = (k % 2 == 0);
         cfg_len = 8'd7;
         @(negedge clk);
         #1;
         checks++;
         if (out_valid !== 1'b1 || out_data !== acc_bw'(48))
            $display("FAIL bp_hold: cycle %0d out_valid=%b out_data=%0d want 1 48",
                     k, out_valid, $signed(out_data));
         else passed++;
      end
      start = 1'b0;
      accept();
      @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) $display("FAIL bp_no_queue: busy=%b want 0", busy);
      else passed++;
   endtask

   task automatic test_reset_mid_job;
      start_job(8'd4);
      in_a = fill(8'd1);
      in_b = fill(8'd1);
      in_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || mac_a !== '0)
         $display("FAIL abort: busy=%b in_ready=%b out_valid=%b mac_a=%h want 0 0 0 0",
                  busy, in_ready, out_valid, mac_a);
      else passed++;
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      start_job(8'd1);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      wait_out(10);
      checks++;
      if (out_data !== acc_bw'(8))
         $display("FAIL after_abort: out_data=%0d want 8", $signed(out_data));
      else passed++;
      accept();
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_bubbles();
      test_zero_len();
      test_max_len();
      test_backpressure();
      test_reset_mid_job();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
